mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mips_mem_pkg.sv | 44 ++++
 rtl/mem_access_if.sv | 21 ++
 rtl/load_align.sv | 32 +++
 rtl/mem_access.sv | 144 ++++++++++++++
 tb/tb_mem_access.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage bus access block: access sizes, FSM states, timeout.
// Also holds the store-side lane helpers used when the request registers are loaded.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    MS_BYTE  = 2'b00,
    MS_HALF  = 2'b01,
    MS_WORD  = 2'b10,
    MS_WORDX = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_TIMEOUT = 255;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MS_BYTE: is_misaligned = 1'b0;
      MS_HALF: is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MS_BYTE: store_be = 4'b0001 << off;
      MS_HALF: store_be = 4'b0011 << off;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      MS_BYTE: store_data = {4{wd[7:0]}};
      MS_HALF: store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Word-addressed memory bus between the MEM stage (master) and the memory (slave).
// Single outstanding request, completed by a one-cycle mem_ready strobe.
interface mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/load_align.sv
// Picks the addressed lane(s) out of a read word and zero/sign-extends to 32 bits.
// Purely combinational; little-endian lanes, lane k = bits [8k+7:8k].
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (off)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      MS_BYTE: data = {{24{sgn & lane_b[7]}}, lane_b};
      MS_HALF: data = {{16{sgn & lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store sequencer: IDLE -> BUSY -> DONE, stalling the pipeline 2+N cycles.
// Waits on mem_ready in BUSY; gives up with a bus_error pulse after TIMEOUT empty cycles.
module mem_access
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  mem_access_if.master      bus,
  output logic [31:0]       memdata_out,
  output logic              stall,
  output logic              misalign,
  output logic              bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdout_q, rdout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               berr_q, berr_d;
  logic [1:0]         size_q, size_d;
  logic [1:0]         off_q, off_d;
  logic               sgn_q, sgn_d;
  logic               access;
  logic [31:0]        load_data;

  // Alignment uses the size/offset latched at request time, not the live pipeline inputs.
  load_align u_load_align (
    .rdata (bus.mem_rdata),
    .off   (off_q),
    .size  (size_q),
    .sgn   (sgn_q),
    .data  (load_data)
  );

  assign access   = MemRead | MemWrite;
  assign misalign = access & is_misaligned(MemSize, addr[1:0]);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdout_d = rdout_q;
    cnt_d   = cnt_q;
    berr_d  = 1'b0;
    size_d  = size_q;
    off_d   = off_q;
    sgn_d   = sgn_q;
    stall   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (access && !misalign) begin
          stall   = 1'b1;
          state_d = S_BUSY;
          req_d   = 1'b1;
          we_d    = MemWrite;
          addr_d  = {addr[31:2], 2'b00};
          be_d    = MemWrite ? store_be(MemSize, addr[1:0]) : 4'b1111;
          wdata_d = store_data(MemSize, wdata);
          size_d  = MemSize;
          off_d   = addr[1:0];
          sgn_d   = MemSigned;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (bus.mem_ready) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!we_q) begin
            rdout_d = load_data;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          rdout_d = '0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdout_q <= '0;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdout_q <= rdout_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
      size_q  <= size_d;
      off_q   <= off_d;
      sgn_q   <= sgn_d;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;
  assign memdata_out   = rdout_q;
  assign bus_error     = berr_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a scoreboard of expected access results, checked in DONE.
module tb_mem_access;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, MemSigned;
  logic [1:0]  MemSize;
  logic [31:0] addr, wdata;
  logic [31:0] memdata_out;
  logic        stall, misalign, bus_error;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemSize     (MemSize),
    .MemSigned   (MemSigned),
    .addr        (addr),
    .wdata       (wdata),
    .bus         (bus),
    .memdata_out (memdata_out),
    .stall       (stall),
    .misalign    (misalign),
    .bus_error   (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
    logic        berr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] sz, input logic sg);
    logic [31:0] sh;
    sh = rd >> (8 * off);
    case (sz)
      2'b00:   return sg ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      2'b01:   return sg ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // waits >= TMO means mem_ready is never raised, so the access must time out.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic sg, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rdat, input int waits);
    exp_t        e, got;
    int          stalls, busy;
    logic        done;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        o_we;

    @(negedge clk);
    MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg; addr = a; wdata = wd;
    bus.mem_ready = 1'b0;
    e.we    = wr;
    e.addr  = a & 32'hFFFF_FFFC;
    e.be    = wr ? model_be(sz, a[1:0]) : 4'hF;
    e.wdata = model_wdata(sz, wd);
    if (waits >= TMO) begin
      e.berr = 1'b1; e.data = 32'h0; e.stalls = TMO + 1;
    end else begin
      e.berr = 1'b0;
      e.data = wr ? model_mem : model_load(rdat, a[1:0], sz, sg);
      e.stalls = waits + 2;
    end
    model_mem = e.data;
    sb.push_back(e);

    stalls = 0; busy = 0; done = 1'b0;
    o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
    #1;
    chk({tag, "_misalign"}, 32'(misalign), 32'd0);
    for (int cyc = 0; cyc < TMO + 20 && !done; cyc++) begin
      if (!stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (bus.mem_req) begin
          if (busy == 0) begin
            o_addr = bus.mem_addr; o_wdata = bus.mem_wdata; o_be = bus.mem_be; o_we = bus.mem_we;
          end
          if (busy == waits) begin
            bus.mem_ready = 1'b1; bus.mem_rdata = rdat;
          end else begin
            bus.mem_ready = 1'b0; bus.mem_rdata = $urandom;
          end
          busy++;
        end
        @(negedge clk); #1;
      end
    end

    chk({tag, "_completed"}, 32'(done), 32'd1);
    got = sb.pop_front();
    chk({tag, "_stalls"},   32'(stalls),        32'(got.stalls));
    chk({tag, "_memdata"},  memdata_out,        got.data);
    chk({tag, "_buserr"},   32'(bus_error),     32'(got.berr));
    chk({tag, "_we"},       32'(o_we),          32'(got.we));
    chk({tag, "_addr"},     o_addr,             got.addr);
    chk({tag, "_be"},       32'(o_be),          32'(got.be));
    if (got.we) chk({tag, "_wdata"}, o_wdata, got.wdata);
    chk({tag, "_done_req"}, 32'(bus.mem_req),   32'd0);
    chk({tag, "_done_be"},  32'(bus.mem_be),    32'(got.be));

    // Pipeline advances; a stray mem_ready in IDLE must have no effect.
    MemRead = 1'b0; MemWrite = 1'b0;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5A5A_5A5A;
    @(negedge clk); #1;
    chk({tag, "_idle_stall"},   32'(stall),       32'd0);
    chk({tag, "_idle_berr"},    32'(bus_error),   32'd0);
    chk({tag, "_idle_req"},     32'(bus.mem_req), 32'd0);
    chk({tag, "_idle_memdata"}, memdata_out,      got.data);
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b10; MemSigned = 1'b0;
    addr = '0; wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    #1;
    chk("rst_req",     32'(bus.mem_req),   32'd0);
    chk("rst_we",      32'(bus.mem_we),    32'd0);
    chk("rst_addr",    bus.mem_addr,       32'd0);
    chk("rst_be",      32'(bus.mem_be),    32'd0);
    chk("rst_wdata",   bus.mem_wdata,      32'd0);
    chk("rst_memdata", memdata_out,        32'd0);
    chk("rst_berr",    32'(bus_error),     32'd0);
    chk("rst_stall",   32'(stall),         32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_access("lw_100",   1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 0);
    run_access("lb_103",   1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,          32'h80FF_FFFF, 0);
    run_access("lbu_103",  1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,          32'h80FF_FFFF, 0);
    run_access("sh_102",   1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD,  32'h0,         0);
    run_access("sb_101",   1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_0055,  32'h0,         1);
    run_access("lh_102",   1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,          32'h8001_1234, 3);
    run_access("lhu_100",  1'b1, 1'b0, 2'b01, 0,    32'h0000_0100, 32'h0,          32'hABCD_F00D, 2);
    run_access("rw_sw11",  1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0200, 32'hCAFE_F00D,  32'h1111_1111, 0);
    run_access("lw_w254",  1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0204, 32'h0,          32'h0BAD_CAFE, TMO - 1);
    run_access("lw_tmo",   1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0,          32'h0,         1000);

    // Misaligned requests: no bus activity, no stall, load result untouched.
    @(negedge clk);
    MemRead = 1'b1; MemSize = 2'b10; addr = 32'h0000_0101;
    #1;
    chk("mis_lw_flag",  32'(misalign), 32'd1);
    chk("mis_lw_stall", 32'(stall),    32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("mis_lw_req", 32'(bus.mem_req), 32'd0);
    end
    chk("mis_lw_memdata", memdata_out, model_mem);
    MemSize = 2'b01; addr = 32'h0000_0103; #1;
    chk("mis_lh_flag", 32'(misalign), 32'd1);
    MemSize = 2'b00; #1;
    chk("mis_lb_flag", 32'(misalign), 32'd0);
    MemRead = 1'b0; MemSize = 2'b10; addr = 32'h0000_0102; #1;
    chk("mis_noacc_flag", 32'(misalign), 32'd0);

    // Reset in the middle of BUSY, then the still-pending load restarts from IDLE.
    @(negedge clk);
    MemRead = 1'b1; MemSize = 2'b10; addr = 32'h0000_0400; bus.mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("rb_busy_req", 32'(bus.mem_req), 32'd1);
    @(negedge clk); #1;
    rst = 1'b1; #1;
    chk("rb_req",     32'(bus.mem_req), 32'd0);
    chk("rb_addr",    bus.mem_addr,     32'd0);
    chk("rb_be",      32'(bus.mem_be),  32'd0);
    chk("rb_memdata", memdata_out,      32'd0);
    chk("rb_berr",    32'(bus_error),   32'd0);
    model_mem = 32'h0;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("rb_idle_req",   32'(bus.mem_req), 32'd0);
    chk("rb_idle_stall", 32'(stall),       32'd1);
    @(negedge clk); #1;
    chk("rb_restart_req",  32'(bus.mem_req), 32'd1);
    chk("rb_restart_addr", bus.mem_addr,     32'h0000_0400);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h600D_F00D;
    @(negedge clk); #1;
    chk("rb_done_stall",   32'(stall),       32'd0);
    chk("rb_done_memdata", memdata_out,      32'h600D_F00D);
    MemRead = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
